// File: rtl/luks_spi_pkg.sv
// luks_spi_pkg: opcodes, FSM encoding and JEDEC ID byte selection shared by the SPI flash responder.
package luks_spi_pkg;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RES  = 8'hAB;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DATA, ST_ID, ST_IGNORE} state_t;

    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'hFF;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with a third history flop; toggle flags any change of the synced level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic toggle
);
    logic [2:0] s;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s <= {3{RST_VAL}};
        else        s <= {s[1:0], din};

    assign level  = s[1];
    assign toggle = s[1] ^ s[2];
endmodule

// File: rtl/spi_flash_resp.sv
// spi_flash_resp: SPI mode-0 flash responder serving READ (0x03) from a byte memory and JEDEC ID (0x9F).
module spi_flash_resp #(
    parameter int          MEM_AW   = 8,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_csb,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);
    import luks_spi_pkg::*;

    localparam int SW = MEM_AW > 8 ? MEM_AW : 8;

    logic          cs_level, cs_edge, sck_level, sck_edge, sck_rise, sck_fall;
    logic [1:0]    mosi_s, id_idx, warm;
    logic          armed, cap;
    logic [4:0]    bit_cnt;
    logic [SW-2:0] shreg;
    logic [SW-1:0] shin;
    logic [7:0]    tx;
    state_t        state;

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs  (.clk(clk), .rst_n(rst_n), .din(spi_csb),  .level(cs_level),  .toggle(cs_edge));
    spi_sync_edge #(.RST_VAL(1'b0)) u_sck (.clk(clk), .rst_n(rst_n), .din(spi_sclk), .level(sck_level), .toggle(sck_edge));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mosi_s <= '0;
        else        mosi_s <= {mosi_s[0], spi_mosi};

    assign sck_rise = sck_edge & sck_level;
    assign sck_fall = sck_edge & ~sck_level;
    assign shin     = {shreg, mosi_s[1]};

    // armed only after the synced CSB has been seen high post-reset, so a CSB held low at release is ignored
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            tx          <= '0;
            id_idx      <= '0;
            warm        <= '0;
            armed       <= 1'b0;
            cap         <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            mem_rd  <= 1'b0;
            cmd_err <= 1'b0;
            cap     <= mem_rd;
            warm    <= warm + {1'b0, warm != 2'd3};
            armed   <= armed | (warm == 2'd3 & cs_level);
            if (cap) tx <= mem_rdata;
            if (cs_level) begin
                state       <= ST_IDLE;
                bit_cnt     <= '0;
                shreg       <= '0;
                tx          <= '0;
                id_idx      <= '0;
                cap         <= 1'b0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
                busy        <= 1'b0;
            end else if (cs_edge && armed) begin
                state   <= ST_CMD;
                bit_cnt <= '0;
                shreg   <= '0;
                busy    <= 1'b1;
            end else begin
                case (state)
                    ST_CMD: if (sck_rise) begin
                        shreg   <= shin[SW-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt     <= '0;
                            state       <= shin[7:0] == OP_READ ? ST_ADDR : shin[7:0] == OP_RDID ? ST_ID : ST_IGNORE;
                            cmd_err     <= !(shin[7:0] inside {OP_READ, OP_RDID, OP_RES});
                            spi_miso_oe <= shin[7:0] == OP_RDID;
                            tx          <= id_byte(JEDEC_ID, 2'd0);
                            id_idx      <= 2'd1;
                        end
                    end
                    ST_ADDR: if (sck_rise) begin
                        shreg   <= shin[SW-2:0];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt     <= '0;
                            mem_rd      <= 1'b1;
                            mem_addr    <= shin[MEM_AW-1:0];
                            state       <= ST_DATA;
                            spi_miso_oe <= 1'b1;
                        end
                    end
                    ST_DATA: if (sck_fall) begin
                        spi_miso <= tx[7];
                        tx       <= {tx[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt  <= '0;
                            mem_rd   <= 1'b1;
                            mem_addr <= mem_addr + MEM_AW'(1);
                        end
                    end
                    ST_ID: if (sck_fall) begin
                        spi_miso <= tx[7];
                        tx       <= {tx[6:0], 1'b0};
                        bit_cnt  <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd7) begin
                            bit_cnt <= '0;
                            tx      <= id_byte(JEDEC_ID, id_idx);
                            id_idx  <= id_idx + {1'b0, id_idx != 2'd3};
                        end
                    end
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_spi_flash_resp.sv
// tb_spi_flash_resp: directed SPI master transactions against spi_flash_resp with a memory of mem[i]=i^0xA5.
module tb_spi_flash_resp;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       spi_csb = 1'b1;
    logic       spi_sclk = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, mem_rd, busy, cmd_err;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata = 8'h00;
    logic [7:0] rx;
    logic [7:0] alog [$];
    int         checks = 0, errors = 0;
    int         rd_cnt = 0, err_cnt = 0, oe_cnt = 0, miso_bad = 0;
    int         s_rd, s_err, s_oe;

    spi_flash_resp #(.MEM_AW(8), .JEDEC_ID(24'hEF4016)) dut (
        .clk(clk), .rst_n(rst_n), .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr ^ 8'hA5;

    always @(negedge clk) begin
        if (mem_rd) begin
            rd_cnt++;
            alog.push_back(mem_addr);
        end
        if (cmd_err) err_cnt++;
        if (spi_miso_oe) oe_cnt++;
        if (!spi_miso_oe && spi_miso) miso_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] b, input int n = 8);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (5) @(posedge clk);
            #1 rx[i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (5) @(posedge clk);
            #1 spi_sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_csb = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic cs_high();
        repeat (3) @(posedge clk);
        #1 spi_csb = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_rd  = rd_cnt;
        s_err = err_cnt;
        s_oe  = oe_cnt;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_miso"}, spi_miso, 1'b0);
        check({tag, "_oe"}, spi_miso_oe, 1'b0);
        check({tag, "_mem_rd"}, mem_rd, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, 8'h00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_cmd_err"}, cmd_err, 1'b0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // read 4 bytes from 0x10
        alog.delete();
        cs_low();
        xfer(8'h03);
        check("read_busy", busy, 1'b1);
        xfer(8'h00); xfer(8'h00); xfer(8'h10);
        xfer(8'h00); check("read_b0", rx, 8'hB5);
        xfer(8'h00); check("read_b1", rx, 8'hB4);
        xfer(8'h00); check("read_b2", rx, 8'hB7);
        xfer(8'h00); check("read_b3", rx, 8'hB6);
        cs_high();
        check("read_busy_end", busy, 1'b0);
        check("read_nrd", alog.size(), 5);
        check("read_a0", alog[0], 8'h10);
        check("read_a1", alog[1], 8'h11);
        check("read_a2", alog[2], 8'h12);
        check("read_a3", alog[3], 8'h13);

        // address wrap at top of memory
        alog.delete();
        cs_low();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'hFF);
        xfer(8'h00); check("wrap_b0", rx, 8'h5A);
        xfer(8'h00); check("wrap_b1", rx, 8'hA5);
        cs_high();
        check("wrap_a0", alog[0], 8'hFF);
        check("wrap_a1", alog[1], 8'h00);

        // JEDEC ID then 0xFF padding
        snap();
        cs_low();
        xfer(8'h9F);
        xfer(8'h00); check("id_b0", rx, 8'hEF);
        xfer(8'h00); check("id_b1", rx, 8'h40);
        xfer(8'h00); check("id_b2", rx, 8'h16);
        xfer(8'h00); check("id_b3", rx, 8'hFF);
        cs_high();
        check("id_no_rd", rd_cnt - s_rd, 0);

        // unsupported opcode
        snap();
        cs_low();
        xfer(8'h5A); xfer(8'hFF); xfer(8'hFF);
        cs_high();
        check("bad_err_pulses", err_cnt - s_err, 1);
        check("bad_oe", oe_cnt - s_oe, 0);
        check("bad_no_rd", rd_cnt - s_rd, 0);

        // 0xAB is accepted and ignored
        snap();
        cs_low();
        xfer(8'hAB); xfer(8'h00);
        cs_high();
        check("ab_err", err_cnt - s_err, 0);
        check("ab_oe", oe_cnt - s_oe, 0);

        // abort mid-byte, then a clean read
        cs_low();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h30);
        xfer(8'h00); check("abort_b0", rx, 8'h95);
        xfer(8'h00, 4);
        spi_csb = 1'b1;
        snap();
        repeat (4) @(posedge clk);
        #1 check("abort_busy", busy, 1'b0);
        check("abort_oe", spi_miso_oe, 1'b0);
        repeat (10) @(posedge clk);
        #1 check("abort_no_rd", rd_cnt - s_rd, 0);
        cs_low();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h20);
        xfer(8'h00); check("post_abort_b0", rx, 8'h85);
        xfer(8'h00); check("post_abort_b1", rx, 8'h84);
        cs_high();

        // reset during ADDR with CSB held low through release
        cs_low();
        xfer(8'h03); xfer(8'h00);
        rst_n = 1'b0;
        #1 check_outputs_zero("mid_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        snap();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h05); xfer(8'h00);
        check("stuck_cs_busy", busy, 1'b0);
        check("stuck_cs_rd", rd_cnt - s_rd, 0);
        check("stuck_cs_oe", oe_cnt - s_oe, 0);
        cs_high();
        cs_low();
        xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h05);
        xfer(8'h00); check("after_reset_b0", rx, 8'hA0);
        cs_high();

        check("miso_zero_when_undriven", miso_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_flash_resp.md
SPI_FLASH_RESP -- requirements
Module: spi_flash_resp

Interface
REQ-001 Parameter MEM_AW, default 8, SHALL set the internal byte address width (memory depth 2^MEM_AW).
REQ-002 Parameter JEDEC_ID, default 24'hEF4016, SHALL set the 3-byte ID returned by command 0x9F.
REQ-003 clk  input  1  system clock, the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 spi_csb  input  1  SPI chip select, active low, asynchronous to clk.
REQ-006 spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-007 spi_mosi  input  1  SPI data from master.
REQ-008 spi_miso  output  1  SPI data to master.
REQ-009 spi_miso_oe  output  1  MISO drive enable.
REQ-010 mem_rd  output  1  one-cycle byte read strobe.
REQ-011 mem_addr  output  MEM_AW  byte address, valid while mem_rd is high.
REQ-012 mem_rdata  input  8  read data, valid exactly 1 clk after mem_rd.
REQ-013 busy  output  1  high while a transaction is in progress (CSB low after sync).
REQ-014 cmd_err  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-015 spi_csb, spi_sclk and spi_mosi SHALL each pass through a 2-flop synchronizer; SCLK edges SHALL be detected from the synchronized value (3-flop history).
REQ-016 The block SHALL support an SCLK period of 8 clk or longer, with each SCLK phase lasting 4 clk or longer.
REQ-017 MOSI SHALL be sampled on detected SCLK rising edges, MSB first.
REQ-018 MISO SHALL update on detected SCLK falling edges, MSB first.
REQ-019 FSM states: IDLE, CMD, ADDR, DATA, ID, IGNORE.
REQ-020 A synchronized CSB falling edge SHALL enter CMD and clear the bit counter.
REQ-021 After 8 command bits, opcode 0x03 SHALL go to ADDR, 0x9F SHALL go to ID, and 0xAB SHALL go to IGNORE without error.
REQ-022 Any other opcode SHALL pulse cmd_err for 1 clk and go to IGNORE.
REQ-023 ADDR SHALL shift in 24 bits; only the low MEM_AW bits SHALL be kept, so upper bits alias.
REQ-024 On the clk after the 24th address bit is sampled, mem_rd SHALL pulse with mem_addr equal to the address.
REQ-025 mem_rdata SHALL be captured into the TX shift register, and its MSB SHALL appear on spi_miso at the next falling edge; the state is then DATA.
REQ-026 In DATA, when bit 0 of the current byte is presented, mem_rd SHALL pulse for address+1.
REQ-027 The address SHALL wrap from 2^MEM_AW-1 to 0.
REQ-028 Reads SHALL stream indefinitely until CSB rises.
REQ-029 ID SHALL shift out JEDEC_ID MSB first (3 bytes), then return 0xFF bytes.
REQ-030 spi_miso_oe SHALL be high only in DATA and ID.
REQ-031 spi_miso SHALL be 0 whenever spi_miso_oe is low.
REQ-032 A synchronized CSB rise in any state, including mid-byte, SHALL return the FSM to IDLE within 1 clk: no further mem_rd, partial bits discarded, spi_miso_oe low.
REQ-033 If CSB rises on the same clk as a detected SCLK edge, the CSB rise SHALL take priority.
REQ-034 SCLK edges while in IDLE SHALL be ignored.

Reset
REQ-035 While rst_n is low, all outputs SHALL be 0, the FSM SHALL be IDLE, all counters and shift registers SHALL be 0, and synchronizer flops SHALL reset to CSB=1, SCLK=0, MOSI=0.
REQ-036 Assertion of rst_n mid-transaction SHALL abort immediately.
REQ-037 After reset release, the block SHALL wait for a fresh CSB falling edge; a CSB already low at release SHALL NOT start a transaction.

Structure
REQ-038 Opcodes (0x03, 0x9F, 0xAB) and the FSM state encoding SHALL live in the shared package luks_spi_pkg.
REQ-039 The synchronizer plus edge detector SHALL be a sub-module named spi_sync_edge, instantiated for sclk and csb.

Verification
REQ-040 Read: CSB low, 0x03, address 0x000010, 4 bytes with memory[i]=i^0xA5 -> MISO bytes 0xB5,0xB4,0xB7,0xB6; mem_addr sequence 0x10..0x13.
REQ-041 Wrap: read at address 0x0000FF, 2 bytes -> mem_addr 0xFF then 0x00; data memory[255], memory[0].
REQ-042 ID: 0x9F then 4 bytes -> 0xEF,0x40,0x16,0xFF; no mem_rd pulse.
REQ-043 Bad opcode: 0x5A -> cmd_err single pulse; spi_miso_oe stays 0 for the remaining clocks; no mem_rd.
REQ-044 Abort: CSB raised after bit 3 of the second data byte -> busy and spi_miso_oe low within 4 clk; a following 0x03 read at 0x000020 returns correct data.
REQ-045 Reset: rst_n pulsed low during ADDR -> all outputs 0; CSB held low at release yields no activity until CSB cycles high then low.
